// File: rtl/pixel_pingpong_buffer.sv
// Double-buffered pixel store between the image reader and the display.
// The reader fills one bank while the display drains the other. Each bank
// walks EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY, and the banks are
// used strictly in turn (0,1,0,1) on both the write side and the read side.
module pixel_pingpong_buffer #(
   parameter int DEPTH = 10000,
   parameter int PTR_W = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] pix_in,
   input  logic        pix_in_valid,
   output logic        Buf0Empty,
   output logic        Buf1Empty,
   output logic [23:0] disp_data,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic        disp_sof,
   output logic        disp_eof,
   output logic        disp_bank,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_FULL,
      ST_DRAINING
   } bank_state_e;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   // A bank that is EMPTY or FILLING may still take pixels from the reader.
   function automatic logic is_open(input bank_state_e s);
      return (s == ST_EMPTY) || (s == ST_FILLING);
   endfunction

   bank_state_e      state_q [2];
   bank_state_e      state_d [2];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             buf0_empty_q, buf1_empty_q;
   logic [23:0]      mem_q [2][DEPTH];

   logic wr_en;
   logic rd_valid;
   logic rd_xfer;

   // The write bank accepts pixels only while open; the read bank is
   // presentable only once it is FULL, so the two never coincide.
   assign wr_en    = pix_in_valid && is_open(state_q[wr_bank_q]);
   assign rd_valid = (state_q[rd_bank_q] == ST_FULL) ||
                     (state_q[rd_bank_q] == ST_DRAINING);
   assign rd_xfer  = rd_valid && disp_ready;

   // Next-state logic for both bank FSMs, pointers, bank selects and overflow.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is
      // inferred; blocking assignments are correct here because this block is
      // combinational, whereas the clocked blocks below use non-blocking ones.
      state_d[0] = state_q[0];
      state_d[1] = state_q[1];
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;

      // Write side: store into the open bank, close it on the last pixel.
      if (wr_en) begin
         if (wr_ptr_q == LAST_PTR) begin
            state_d[wr_bank_q] = ST_FULL;
            wr_ptr_d           = '0;
            wr_bank_d          = ~wr_bank_q;
         end else begin
            state_d[wr_bank_q] = ST_FILLING;
            wr_ptr_d           = wr_ptr_q + 1'b1;
         end
      end else if (pix_in_valid) begin
         // Reader pushed into a bank that is still full or being drained.
         overflow_d = 1'b1;
      end

      // Read side: first presented cycle moves FULL to DRAINING; the final
      // transfer frees the bank and hands over to the other one.
      if (rd_xfer && (rd_ptr_q == LAST_PTR)) begin
         state_d[rd_bank_q] = ST_EMPTY;
         rd_ptr_d           = '0;
         rd_bank_d          = ~rd_bank_q;
      end else if (rd_valid) begin
         state_d[rd_bank_q] = ST_DRAINING;
         if (rd_xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   // State register; reset abandons any partial fill or drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q[0]   <= ST_EMPTY;
         state_q[1]   <= ST_EMPTY;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         buf0_empty_q <= 1'b1;
         buf1_empty_q <= 1'b1;
      end else begin
         state_q[0]   <= state_d[0];
         state_q[1]   <= state_d[1];
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         buf0_empty_q <= is_open(state_d[0]);
         buf1_empty_q <= is_open(state_d[1]);
      end
   end

   // Pixel storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the pixel array has no reset; stale contents are never exposed
      // because a bank is only read after it has been completely rewritten.
      if (wr_en) begin
         mem_q[wr_bank_q][wr_ptr_q] <= pix_in;
      end
   end

   assign Buf0Empty  = buf0_empty_q;
   assign Buf1Empty  = buf1_empty_q;
   assign disp_data  = mem_q[rd_bank_q][rd_ptr_q];
   assign disp_valid = rd_valid;
   assign disp_sof   = rd_valid && (rd_ptr_q == '0);
   assign disp_eof   = rd_valid && (rd_ptr_q == LAST_PTR);
   assign disp_bank  = rd_bank_q;
   assign overflow   = overflow_q;

   // The reader and the display must never touch the same bank in one cycle.
   a_no_same_bank_access: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(wr_en && rd_valid && (wr_bank_q == rd_bank_q))
   );

endmodule

// File: tb/tb_pixel_pingpong_buffer.sv
// Directed bench for pixel_pingpong_buffer with four pixels per bank.
module tb_pixel_pingpong_buffer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic        clk;
   logic        rst_n;
   logic [23:0] pix_in;
   logic        pix_in_valid;
   logic        Buf0Empty;
   logic        Buf1Empty;
   logic [23:0] disp_data;
   logic        disp_valid;
   logic        disp_ready;
   logic        disp_sof;
   logic        disp_eof;
   logic        disp_bank;
   logic        overflow;

   int n_checks;
   int n_fail;

   pixel_pingpong_buffer #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_in       (pix_in),
      .pix_in_valid (pix_in_valid),
      .Buf0Empty    (Buf0Empty),
      .Buf1Empty    (Buf1Empty),
      .disp_data    (disp_data),
      .disp_valid   (disp_valid),
      .disp_ready   (disp_ready),
      .disp_sof     (disp_sof),
      .disp_eof     (disp_eof),
      .disp_bank    (disp_bank),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_px(input logic [23:0] p);
      pix_in       = p;
      pix_in_valid = 1'b1;
      tick();
      pix_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [23:0] exp8 [8];
      int          idx;

      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      pix_in       = '0;
      pix_in_valid = 1'b0;
      disp_ready   = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Reset then idle.
      check("rst_buf0",     32'(Buf0Empty),  32'h1);
      check("rst_buf1",     32'(Buf1Empty),  32'h1);
      check("rst_valid",    32'(disp_valid), 32'h0);
      check("rst_overflow", 32'(overflow),   32'h0);
      check("rst_bank",     32'(disp_bank),  32'h0);
      check("rst_sof",      32'(disp_sof),   32'h0);
      check("rst_eof",      32'(disp_eof),   32'h0);

      // Fill bank 0 with 1..4 while the display is ready.
      disp_ready = 1'b1;
      write_px(24'h000001);
      write_px(24'h000002);
      write_px(24'h000003);
      check("fill3_buf0",  32'(Buf0Empty),  32'h1);
      check("fill3_valid", 32'(disp_valid), 32'h0);
      write_px(24'h000004);
      check("fill4_buf0", 32'(Buf0Empty), 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("t2_valid", 32'(disp_valid), 32'h1);
         check("t2_data",  32'(disp_data),  32'(i + 1));
         check("t2_sof",   32'(disp_sof),   32'(i == 0));
         check("t2_eof",   32'(disp_eof),   32'(i == 3));
         check("t2_bank",  32'(disp_bank),  32'h0);
         tick();
      end
      check("t2_done_valid", 32'(disp_valid), 32'h0);
      check("t2_done_buf0",  32'(Buf0Empty),  32'h1);
      check("t2_done_bank",  32'(disp_bank),  32'h1);

      // Fill both banks with the display stalled, then overflow.
      do_reset();
      disp_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_px(24'h000010 + 24'(i));
      check("t3_buf0_full", 32'(Buf0Empty),  32'h0);
      check("t3_valid",     32'(disp_valid), 32'h1);
      for (int i = 0; i < 4; i++) write_px(24'h0000A0 + 24'(i));
      check("t3_buf0", 32'(Buf0Empty), 32'h0);
      check("t3_buf1", 32'(Buf1Empty), 32'h0);
      check("t3_hold", 32'(disp_data), 32'h10);
      check("t3_no_ovf", 32'(overflow), 32'h0);
      write_px(24'hFFFFFF);
      check("t3_overflow", 32'(overflow), 32'h1);
      disp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t3_stream_valid", 32'(disp_valid), 32'h1);
         check("t3_stream_data",  32'(disp_data),
               (i < 4) ? 32'h10 + 32'(i) : 32'hA0 + 32'(i - 4));
         check("t3_stream_bank",  32'(disp_bank),  32'(i >= 4));
         tick();
      end
      check("t3_end_valid", 32'(disp_valid), 32'h0);
      check("t3_end_buf0",  32'(Buf0Empty),  32'h1);
      check("t3_end_buf1",  32'(Buf1Empty),  32'h1);
      check("t3_sticky",    32'(overflow),   32'h1);

      // Backpressure across both banks with a 1,0,0 ready pattern.
      disp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp8[i]     = 24'h000021 + 24'(i);
         exp8[i + 4] = 24'h000031 + 24'(i);
      end
      for (int i = 0; i < 8; i++) write_px(exp8[i]);
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         disp_ready = (c % 3 == 0);
         check("bp_valid", 32'(disp_valid), 32'h1);
         check("bp_data",  32'(disp_data),  32'(exp8[idx]));
         tick();
         if (disp_ready) idx++;
      end
      disp_ready = 1'b0;
      check("bp_count", 32'(idx), 32'd8);
      check("bp_end_valid", 32'(disp_valid), 32'h0);

      // Drain bank 0 while filling bank 1; last read meets last write.
      for (int i = 0; i < 4; i++) write_px(24'h000041 + 24'(i));
      disp_ready   = 1'b1;
      pix_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pix_in = 24'h000051 + 24'(i);
         check("cc_data", 32'(disp_data), 32'h41 + 32'(i));
         check("cc_bank", 32'(disp_bank), 32'h0);
         tick();
      end
      pix_in_valid = 1'b0;
      check("cc_buf0",  32'(Buf0Empty),  32'h1);
      check("cc_buf1",  32'(Buf1Empty),  32'h0);
      check("cc_bank1", 32'(disp_bank),  32'h1);
      check("cc_valid", 32'(disp_valid), 32'h1);
      check("cc_first", 32'(disp_data),  32'h51);
      check("cc_sof",   32'(disp_sof),   32'h1);
      for (int i = 0; i < 4; i++) begin
         check("cc_b1_data", 32'(disp_data), 32'h51 + 32'(i));
         tick();
      end
      check("cc_end_valid", 32'(disp_valid), 32'h0);

      // Reset in the middle of a drain, then refill bank 0.
      disp_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_px(24'h000061 + 24'(i));
      disp_ready = 1'b1;
      tick();
      tick();
      disp_ready = 1'b0;
      check("mr_data",     32'(disp_data), 32'h63);
      check("mr_ovf_pre",  32'(overflow),  32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_async_valid", 32'(disp_valid), 32'h0);
      check("mr_async_buf0",  32'(Buf0Empty),  32'h1);
      check("mr_async_buf1",  32'(Buf1Empty),  32'h1);
      check("mr_async_ovf",   32'(overflow),   32'h0);
      check("mr_async_bank",  32'(disp_bank),  32'h0);
      check("mr_async_sof",   32'(disp_sof),   32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) write_px(24'h000071 + 24'(i));
      check("rf_sof",  32'(disp_sof),  32'h1);
      check("rf_bank", 32'(disp_bank), 32'h0);
      disp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rf_valid", 32'(disp_valid), 32'h1);
         check("rf_data",  32'(disp_data),  32'h71 + 32'(i));
         check("rf_eof",   32'(disp_eof),   32'(i == 3));
         tick();
      end
      check("rf_end_valid", 32'(disp_valid), 32'h0);
      check("rf_end_buf0",  32'(Buf0Empty),  32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_pingpong_buffer.md
Name: pixel_pingpong_buffer

Overview:
- Double-buffered (ping-pong) pixel store directly downstream of the image reader stage.
- Accepts 24-bit RGB pixels on its write side and tells the reader which bank needs filling via Buf0Empty/Buf1Empty.
- Drains completed banks to the display-side consumer over a valid/ready stream.
- Lets the display read one bank while the reader fills the other.

Parameters:
- DEPTH, 10000: pixels per bank (a 100x100 image at 3 bytes per pixel = 30000 bytes).
- PTR_W, 14: pointer width; must satisfy 2**PTR_W >= DEPTH.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in  in  24  pixel from the reader, {B,G,R} byte order as produced upstream.
- pix_in_valid  in  1  pix_in is a pixel to store this cycle.
- Buf0Empty  out  1  bank 0 is EMPTY or FILLING (reader may supply image 1).
- Buf1Empty  out  1  bank 1 is EMPTY or FILLING (reader may supply image 2).
- disp_data  out  24  pixel at the read pointer of the read bank.
- disp_valid  out  1  disp_data is valid.
- disp_ready  in  1  display accepts disp_data this cycle.
- disp_sof  out  1  disp_valid and first pixel of a bank.
- disp_eof  out  1  disp_valid and last pixel (index DEPTH-1).
- disp_bank  out  1  bank currently being read.
- overflow  out  1  sticky; a pixel was dropped.

Behaviour:
- Reset (async assert, sync-to-clk deassert use):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0.
  - Buf0Empty=1, Buf1Empty=1, disp_valid=0, disp_sof=0, disp_eof=0, disp_bank=0, overflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts any fill or drain; the partial bank is discarded.
- Per-bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- BufNEmpty = (state==EMPTY || state==FILLING); registered, so it reflects state after the edge.
- Write side:
  - A write occurs when pix_in_valid=1 and bank[wr_bank] is EMPTY or FILLING.
  - On a write: mem[wr_bank][wr_ptr] <= pix_in; EMPTY -> FILLING.
  - On the write with wr_ptr==DEPTH-1: bank -> FULL, wr_ptr <= 0, wr_bank toggles.
  - pix_in_valid=1 while bank[wr_bank] is FULL or DRAINING: pixel dropped, overflow <= 1 (sticky until reset). This covers the one-cycle reader lag after BufNEmpty falls.
- Read side:
  - disp_valid=1 iff bank[rd_bank] is FULL or DRAINING.
  - disp_data = mem[rd_bank][rd_ptr], read combinationally; zero added latency once the bank is FULL.
  - First valid cycle: FULL -> DRAINING.
  - Handshake: transfer on disp_valid && disp_ready; rd_ptr++.
  - Transfer with rd_ptr==DEPTH-1: bank -> EMPTY, rd_ptr <= 0, rd_bank toggles.
  - disp_valid drops the next cycle unless the other bank is already FULL, in which case streaming continues back-to-back with no bubble.
  - disp_data is held stable while disp_valid && !disp_ready.
- Bank handover:
  - A bank becomes FULL on the cycle after its last write; disp_valid may rise that next cycle (1-cycle fill-to-read latency).
  - The same bank is never written and read concurrently; this is guaranteed by the state exclusivity.
- Simultaneous events:
  - Last write into bank X and last read of bank Y in the same cycle: both take effect.
  - If X==Y is impossible by construction; verify with an assertion.
- Order:
  - Banks alternate strictly: 0,1,0,1 on both sides.
  - A bank filled while the display drains the other waits in FULL.

Test Plan (DEPTH=4):
- Reset then idle:
  - Buf0Empty=1, Buf1Empty=1, disp_valid=0, overflow=0.
  - Asserting rst_n=0 asynchronously mid-cycle clears outputs immediately.
- Fill bank 0 with 4 pixels 0x000001..0x000004, disp_ready=1:
  - Buf0Empty=0 after the 4th edge.
  - disp_valid the next cycle; data 1,2,3,4 with sof on 1 and eof on 4, disp_bank=0.
  - Buf0Empty=1 again after the drain.
- Fill bank 0, then bank 1 (0xA0..0xA3) with disp_ready=0:
  - Both BufNEmpty=0; a 9th pixel sets overflow=1 and is dropped.
  - Then disp_ready=1: 8 pixels stream back-to-back with no bubble, bank 0 then bank 1.
- Backpressure:
  - Toggle disp_ready 1,0,0,1,... during a drain.
  - disp_data is held while stalled; every pixel is delivered exactly once, in order.
- Concurrent:
  - Drain bank 0 while filling bank 1; the last read of bank 0 coincides with the last write of bank 1.
  - Next cycle: bank0 EMPTY (Buf0Empty=1) and disp_bank=1, disp_data=first pixel of bank 1.
- Reset mid-drain after 2 pixels:
  - All state returns to reset values.
  - A refill of bank 0 reads back the new data, starting at index 0.
